// File: rtl/mul_d_pipe.sv
// mul_d_pipe: two-stage pipelined W x W unsigned multiplier feeding the
// Dilithium Barrett reduction stage (red_D). Produces the raw 2*W-bit product
// with a sideband tag, valid/ready on both sides and full backpressure at one
// product per clock.
// Optional feature: define MUL_D_RANGE_CHECK_EN to add err_o, a flag raised
// for any operand pair where a >= Q or b >= Q (the product is still exact).

module mul_d_pipe #(
   parameter int unsigned Q     = 8380417,
   parameter int unsigned W     = 23,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [2*W-1:0]   product_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             valid_o,
   input  logic             ready_i
`ifdef MUL_D_RANGE_CHECK_EN
   ,
   output logic             err_o
`endif
);

   // b is split at bit 12 so each stage-1 multiplier stays narrow.
   localparam int unsigned LO_W = 12;
   localparam int unsigned HI_W = W - LO_W;
   localparam int unsigned PL_W = W + LO_W;   // a * b_lo
   localparam int unsigned PH_W = W + HI_W;   // a * b_hi
   localparam int unsigned P_W  = 2 * W;

   logic             s1_v;
   logic [PL_W-1:0]  s1_plo;
   logic [PH_W-1:0]  s1_phi;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_v;
   logic             adv1;
   logic             adv2;

   logic [PL_W-1:0]  plo;
   logic [PH_W-1:0]  phi;
   logic [P_W-1:0]   sum;

`ifdef MUL_D_RANGE_CHECK_EN
   logic             in_err;
   logic             s1_err;
`endif

   // A stage may load when it is empty or when the stage after it moves on.
   // ready_o therefore depends combinationally on ready_i.
   assign adv2    = !s2_v || ready_i;
   assign adv1    = !s1_v || adv2;
   assign ready_o = adv1;
   assign valid_o = s2_v;

   // Stage-1 partial products from the live operands.
   assign plo = PL_W'(a_i) * PL_W'(b_i[LO_W-1:0]);
   assign phi = PH_W'(a_i) * PH_W'(b_i[W-1:LO_W]);

   // Stage-2 recombination; the sum of two W-bit operands' product fits in 2*W bits.
   assign sum = (P_W'(s1_phi) << LO_W) + P_W'(s1_plo);

`ifdef MUL_D_RANGE_CHECK_EN
   // Out-of-range flag computed at the input and carried with the item.
   assign in_err = (32'(a_i) >= Q) || (32'(b_i) >= Q);
`endif

   // Stage 1: capture partial products, tag and valid whenever stage 1 may advance.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: datapath registers are reset as well because downstream sees
         // product_o/tag_o/err_o and they have defined reset values.
         s1_v   <= 1'b0;
         s1_plo <= '0;
         s1_phi <= '0;
         s1_tag <= '0;
`ifdef MUL_D_RANGE_CHECK_EN
         s1_err <= 1'b0;
`endif
      end else if (adv1) begin
         // NOTE: non-blocking assignments so each stage samples its
         // predecessor's value from before the edge, not the updated one.
         s1_v   <= valid_i && ready_o;
         s1_plo <= plo;
         s1_phi <= phi;
         s1_tag <= tag_i;
`ifdef MUL_D_RANGE_CHECK_EN
         s1_err <= in_err;
`endif
      end
   end

   // Stage 2: form the full product; outputs hold while the consumer stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_v      <= 1'b0;
         product_o <= '0;
         tag_o     <= '0;
`ifdef MUL_D_RANGE_CHECK_EN
         err_o     <= 1'b0;
`endif
      end else if (adv2) begin
         s2_v      <= s1_v;
         product_o <= sum;
         tag_o     <= s1_tag;
`ifdef MUL_D_RANGE_CHECK_EN
         err_o     <= s1_err;
`endif
      end
   end

endmodule

// File: tb/tb_mul_d_pipe.sv
// Testbench for mul_d_pipe: scoreboard of expected products fed by the
// stimulus process, drained by an independent output monitor. Define
// MUL_D_RANGE_CHECK_EN here as well to exercise err_o.

module tb_mul_d_pipe;

   localparam int unsigned W     = 23;
   localparam int unsigned TAG_W = 8;
   localparam int unsigned Q     = 8380417;

   typedef struct {
      logic [2*W-1:0]   p;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_i;
   logic [W-1:0]     a_i;
   logic [W-1:0]     b_i;
   logic [TAG_W-1:0] tag_i;
   logic             valid_i;
   logic             ready_o;
   logic [2*W-1:0]   product_o;
   logic [TAG_W-1:0] tag_o;
   logic             valid_o;
   logic             ready_i;
`ifdef MUL_D_RANGE_CHECK_EN
   logic             err_o;
`endif

   exp_t sb[$];
   int   errors   = 0;
   int   checks   = 0;
   int   outs     = 0;

   mul_d_pipe #(.Q(Q), .W(W), .TAG_W(TAG_W)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .tag_i     (tag_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .product_o (product_o),
      .tag_o     (tag_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i)
`ifdef MUL_D_RANGE_CHECK_EN
      ,
      .err_o     (err_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer product and range test.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [TAG_W-1:0] tag);
      exp_t        e;
      logic [63:0] full;
      full  = 64'(a) * 64'(b);
      e.p   = full[2*W-1:0];
      e.tag = tag;
      e.err = (int'(a) >= int'(Q)) || (int'(b) >= int'(Q));
      return e;
   endfunction

   // One cycle of stimulus: drive just after the edge, decide acceptance at the
   // falling edge (the transfer itself happens on the next rising edge).
   task automatic offer(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic r, output bit acc);
      @(posedge clk);
      #1;
      valid_i = v;
      a_i     = a;
      b_i     = b;
      tag_i   = tag;
      ready_i = r;
      @(negedge clk);
      acc = valid_i && ready_o;
      if (acc) sb.push_back(model(a, b, tag));
   endtask

   // Hold a pair until it is accepted; ready_i chosen per cycle with given percentage.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TAG_W-1:0] tag, input int rdy_pct);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 200 && !acc; i++)
         offer(1'b1, a, b, tag, ($urandom_range(99) < rdy_pct), acc);
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int n, input logic r);
      bit acc;
      for (int i = 0; i < n; i++) offer(1'b0, '0, '0, '0, r, acc);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1, 1'b1);
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Output monitor: pops the scoreboard on every output transfer and checks
   // that a stalled output does not change.
   logic [2*W-1:0]   hold_p;
   logic [TAG_W-1:0] hold_t;
   logic             hold_e;
   bit               stalled = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      logic cur_err;
`ifdef MUL_D_RANGE_CHECK_EN
      cur_err = err_o;
`else
      cur_err = 1'b0;
`endif
      if (rst_i) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("hold_valid",   64'(valid_o),   64'd1);
            check("hold_product", 64'(product_o), 64'(hold_p));
            check("hold_tag",     64'(tag_o),     64'(hold_t));
            check("hold_err",     64'(cur_err),   64'(hold_e));
         end
         if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 64'(valid_o), 64'd0);
            end else begin
               e = sb.pop_front();
               check("product", 64'(product_o), 64'(e.p));
               check("tag",     64'(tag_o),     64'(e.tag));
`ifdef MUL_D_RANGE_CHECK_EN
               check("err",     64'(err_o),     64'(e.err));
`endif
               outs++;
            end
         end
         stalled = valid_o && !ready_i;
         hold_p  = product_o;
         hold_t  = tag_o;
         hold_e  = cur_err;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int k;
      int n_valid;
      int n_rise;
      int outs_before;
      logic prev_v;
      logic [W-1:0] pa[3];
      logic [W-1:0] pb[3];

      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      tag_i   = '0;
      #23;
      // Reset state observed while reset is held.
      check("rst_valid",   64'(valid_o),   64'd0);
      check("rst_product", 64'(product_o), 64'd0);
      check("rst_tag",     64'(tag_o),     64'd0);
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(ready_o), 64'd1);

      // Basic product and latency: valid_o low after the accepting edge,
      // high after the next edge, for exactly one cycle.
      offer(1'b1, 23'd3, 23'd5, 8'h11, 1'b1, acc);
      check("basic_accept", 64'(acc), 64'd1);
      idle(1, 1'b1);
      check("lat_valid_e1", 64'(valid_o), 64'd0);
      idle(1, 1'b1);
      check("lat_valid_e2", 64'(valid_o), 64'd1);
      check("basic_product", 64'(product_o), 64'd15);
      check("basic_tag",     64'(tag_o),     64'h11);
      idle(1, 1'b1);
      check("lat_valid_e3", 64'(valid_o), 64'd0);

      // Maximum in-range operands.
      send(23'd8380416, 23'd8380416, 8'h5A, 100);
      idle(2, 1'b1);
      check("max_product", 64'(product_o), 64'd70231372333056);

      // Streaming: 8 back-to-back pairs, ready_o stays high, 8 contiguous outputs.
      n_valid = 0;
      n_rise  = 0;
      prev_v  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         offer(1'b1, W'(i), 23'd4190208, TAG_W'(i), 1'b1, acc);
         check("stream_ready", 64'(acc), 64'd1);
         if (valid_o && !prev_v) n_rise++;
         if (valid_o) n_valid++;
         prev_v = valid_o;
      end
      for (int i = 0; i < 4; i++) begin
         idle(1, 1'b1);
         if (valid_o && !prev_v) n_rise++;
         if (valid_o) n_valid++;
         prev_v = valid_o;
      end
      check("stream_count", 64'(n_valid), 64'd8);
      check("stream_contig", 64'(n_rise), 64'd1);

      // Backpressure: only two accepts with ready_i low, output holds 6.
      pa[0] = 23'd2; pb[0] = 23'd3;
      pa[1] = 23'd4; pb[1] = 23'd5;
      pa[2] = 23'd6; pb[2] = 23'd7;
      outs_before = outs;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         offer(1'b1, pa[k], pb[k], TAG_W'(8'hB0 + k), 1'b0, acc);
         if (acc) k++;
         if (k == 2 && i >= 2) begin
            check("bp_ready_low", 64'(ready_o),   64'd0);
            check("bp_hold6",     64'(product_o), 64'd6);
         end
      end
      check("bp_accepts", 64'(k), 64'd2);
      send(pa[2], pb[2], 8'hB2, 100);
      drain();
      check("bp_outputs", 64'(outs - outs_before), 64'd3);

      // Async reset mid-stream with both stages full.
      send(23'd11, 23'd13, 8'hC0, 0);
      send(23'd17, 23'd19, 8'hC1, 0);
      idle(1, 1'b0);
      check("rst_full_valid", 64'(valid_o), 64'd1);
      @(posedge clk);
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_valid",   64'(valid_o),   64'd0);
      check("arst_product", 64'(product_o), 64'd0);
      check("arst_tag",     64'(tag_o),     64'd0);
      sb.delete();
      @(negedge clk);
      #1;
      rst_i = 1'b0;
      outs_before = outs;
      idle(1, 1'b1);
      check("arst_ready", 64'(ready_o), 64'd1);
      idle(4, 1'b1);
      check("arst_no_stale", 64'(outs - outs_before), 64'd0);

`ifdef MUL_D_RANGE_CHECK_EN
      // Range flag travels with the item.
      send(23'd8380417, 23'd1, 8'hE0, 100);
      send(23'd1, 23'd1, 8'hE1, 100);
      drain();
`endif

      // Randomised traffic with random gaps and random backpressure.
      for (int i = 0; i < 300; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom_range(Q - 1));
         rb = W'($urandom_range(Q - 1));
`ifdef MUL_D_RANGE_CHECK_EN
         if ($urandom_range(9) == 0) ra = W'($urandom_range((1 << W) - 1));
         if ($urandom_range(9) == 0) rb = W'($urandom_range((1 << W) - 1));
`endif
         send(ra, rb, TAG_W'($urandom), 60);
         if ($urandom_range(3) == 0) idle(int'($urandom_range(3)), logic'($urandom_range(1)));
      end
      drain();
      check("random_outputs_seen", 64'(outs > 300), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
